// File: rtl/io_dispatcher.sv
// Syscall dispatcher: decodes a code from acc and runs a four-phase read/write
// handshake on one of NCHAN device channels, reporting completion, errors and halt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for runio; decodes acc when it is sampled
// S_REQ   | strobe on the selected channel, waiting for ioack or timeout
// S_REL   | strobe dropped, waiting for the selected ioack to fall
// S_HALT  | absorbing halt until reset
module io_dispatcher #(
  parameter int WIDTH   = 16,
  parameter int NCHAN   = 2,
  parameter int TIMEOUT = 255,
  parameter int CW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             runio,
  input  logic [WIDTH-1:0] acc,
  input  logic [NCHAN-1:0] ioack,
  output logic [NCHAN-1:0] io_read,
  output logic [NCHAN-1:0] io_write,
  output logic             acc_write,
  output logic [CW-1:0]    chan_sel,
  output logic             iobusy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             halted
);

  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0]  TO_LAST  = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(2 * NCHAN);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_HALT} state_t;

  state_t          state_q, state_d;
  logic            rd_q, rd_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic             sel_ack;
  logic             code_legal;
  logic             timeout_hit;
  logic [WIDTH-1:0] acc_m1;

  assign sel_ack     = ioack[chan_q];
  assign acc_m1      = acc - WIDTH'(1);
  assign code_legal  = (acc != '0) && (acc <= MAX_CODE);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      chan_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (runio) begin
          err_code_d = 2'b00;
          rd_d       = acc[0];
          chan_d     = code_legal ? CW'(acc_m1 >> 1) : '0;
          if (acc == '0) begin
            state_d = S_HALT;
          end else if (code_legal) begin
            state_d = S_REQ;
            cnt_d   = '0;
          end else begin
            // illegal codes complete straight from IDLE without a handshake
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end
        end
      end
      S_REQ: begin
        if (sel_ack) begin
          state_d = S_REL;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d    = S_REL;
          done_d     = 1'b1;
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_REL: begin
        if (!sel_ack) state_d = S_IDLE;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    io_read   = '0;
    io_write  = '0;
    acc_write = 1'b0;
    if (state_q == S_REQ) begin
      if (rd_q) io_read  = NCHAN'(1) << chan_q;
      else      io_write = NCHAN'(1) << chan_q;
      acc_write = rd_q & sel_ack;
    end
  end

  assign chan_sel = chan_q;
  assign iobusy   = ~done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_io_dispatcher.sv
// Randomized self-checking bench for io_dispatcher (NCHAN=4, TIMEOUT=8); expected
// waveforms are derived per syscall from the handshake rules.
module tb_io_dispatcher;
  localparam int WIDTH   = 16;
  localparam int NCHAN   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             runio;
  logic [WIDTH-1:0] acc;
  logic [NCHAN-1:0] ioack;
  logic [NCHAN-1:0] io_read, io_write;
  logic             acc_write;
  logic [CW-1:0]    chan_sel;
  logic             iobusy, err, halted;
  logic [1:0]       err_code;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_ec = 2'b00;

  io_dispatcher #(.WIDTH(WIDTH), .NCHAN(NCHAN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .runio(runio), .acc(acc), .ioack(ioack),
    .io_read(io_read), .io_write(io_write), .acc_write(acc_write),
    .chan_sel(chan_sel), .iobusy(iobusy), .err(err), .err_code(err_code),
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_rd, input logic [3:0] e_wr,
                            input logic e_aw, input logic e_busy, input logic e_err,
                            input logic [1:0] e_ec, input logic e_halt);
    check_eq({tag, ".io_read"},   32'(io_read),   32'(e_rd));
    check_eq({tag, ".io_write"},  32'(io_write),  32'(e_wr));
    check_eq({tag, ".acc_write"}, 32'(acc_write), 32'(e_aw));
    check_eq({tag, ".iobusy"},    32'(iobusy),    32'(e_busy));
    check_eq({tag, ".err"},       32'(err),       32'(e_err));
    check_eq({tag, ".err_code"},  32'(err_code),  32'(e_ec));
    check_eq({tag, ".halted"},    32'(halted),    32'(e_halt));
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1; runio = 1'b0; ioack = '0; acc = '0;
    step;
    #2;
    check_outs(tag, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check_eq({tag, ".chan_sel"}, 32'(chan_sel), 32'd0);
    exp_ec = 2'b00;
    reset = 1'b0;
    step;
  endtask

  // Legal syscall: ack rises after d unacked strobe cycles (never if d >= TIMEOUT),
  // then stays high for r further cycles once the dispatcher is releasing.
  task automatic do_legal(input int code, input int d, input int r);
    int ch, nreq, nrel;
    logic rd, tmo;
    logic [3:0] mask, strobe;
    ch     = (code - 1) / 2;
    rd     = (code % 2) == 1;
    mask   = 4'(1 << ch);
    tmo    = d >= TIMEOUT;
    nreq   = tmo ? TIMEOUT : d + 1;
    nrel   = tmo ? 1 : r + 1;
    runio  = 1'b1;
    acc    = WIDTH'(code);
    ioack  = 4'($urandom) & ~mask;
    #2;
    check_outs("leg_idle", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, exp_ec, 1'b0);
    step;
    runio  = 1'b0;
    exp_ec = 2'b00;
    for (int j = 0; j < nreq; j++) begin
      ioack  = (4'($urandom) & ~mask) | ((!tmo && j >= d) ? mask : 4'h0);
      strobe = mask;
      #2;
      check_outs("leg_req", rd ? strobe : 4'h0, rd ? 4'h0 : strobe,
                 rd && !tmo && (j == d), 1'b1, 1'b0, 2'b00, 1'b0);
      check_eq("leg_req.chan_sel", 32'(chan_sel), 32'(ch));
      step;
    end
    if (tmo) exp_ec = 2'b10;
    for (int k = 0; k < nrel; k++) begin
      ioack = (4'($urandom) & ~mask) | ((!tmo && k < r) ? mask : 4'h0);
      #2;
      check_outs("leg_rel", 4'h0, 4'h0, 1'b0, k != 0, tmo && (k == 0), exp_ec, 1'b0);
      step;
    end
  endtask

  task automatic do_illegal(input logic [WIDTH-1:0] code);
    runio = 1'b1;
    acc   = code;
    ioack = 4'($urandom);
    #2;
    check_outs("ill_idle", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, exp_ec, 1'b0);
    step;
    runio  = 1'b0;
    ioack  = 4'($urandom);
    exp_ec = 2'b01;
    #2;
    check_outs("ill_done", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, exp_ec, 1'b0);
    step;
    ioack = 4'($urandom);
    #2;
    check_outs("ill_after", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, exp_ec, 1'b0);
    step;
  endtask

  initial begin
    int sel;
    reset = 1'b0; runio = 1'b0; acc = '0; ioack = '0;
    apply_reset("rst");

    do_legal(2, 3, 2);        // write ch0, ack after 3 strobe cycles
    do_legal(3, 1, 0);        // read ch1, ack after 1 cycle, ack drops immediately
    do_illegal(16'd9);
    do_legal(1, 20, 0);       // read ch0, no ack -> timeout
    do_legal(1, 0, 1);        // next legal call clears err_code
    do_legal(8, TIMEOUT - 1, 1); // ack in the last cycle before timeout wins
    do_illegal(16'h8001);     // upper bits must not be ignored
    do_illegal(16'hFFFF);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)
        do_legal(int'($urandom_range(1, 2 * NCHAN)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 3)));
      else if (sel < 9)
        do_illegal(WIDTH'($urandom_range(2 * NCHAN + 1, 2 * NCHAN + 4)));
      else
        do_illegal(WIDTH'($urandom_range(2 * NCHAN + 1, 65535)));
    end

    // halt: absorbing, strobes suppressed, cleared by reset
    runio = 1'b1; acc = '0; ioack = '0;
    #2;
    check_outs("halt_idle", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, exp_ec, 1'b0);
    step;
    exp_ec = 2'b00;
    acc    = WIDTH'(1);
    for (int i = 0; i < 5; i++) begin
      ioack = 4'($urandom);
      #2;
      check_outs("halt", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, exp_ec, 1'b1);
      step;
    end
    apply_reset("halt_rst");

    // reset in the middle of a write request
    runio = 1'b1; acc = WIDTH'(2); ioack = '0;
    step;
    runio = 1'b0;
    #2;
    check_eq("midreq.io_write", 32'(io_write), 32'h1);
    apply_reset("midreq_rst");
    #2;
    check_outs("midreq_after", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
